mult_ctrl: RTL and testbench

- Control FSM directly upstream of the 4x4 shift-add multiplier datapath.
- Accepts a start request and sequences the datapath's clear, load, product-load and shift strobes for N bit-iterations.
- Holds a done flag until the requester acknowledges.
- Outputs wire 1:1 onto the datapath's clr/ld/ldp/shp/shb inputs; pclr drives the datapath clr.

---
 rtl/mult_ctrl.sv | 91 +++++++++
 tb/tb_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing FSM for the 4x4 shift-add multiplier datapath: clear, load, then
// N add/shift iterations, and a held done flag that stays up until ack.
module mult_ctrl #(
  parameter int N = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic ack,
  output logic pclr,
  output logic ld,
  output logic ldp,
  output logic shp,
  output logic shb,
  output logic busy,
  output logic done
);

  localparam int CW = $clog2(N) + 1;

  // state | meaning
  // IDLE  | waiting for start
  // CLEAR | clear datapath product, reset iteration count
  // LOAD  | load multiplicand and multiplier
  // ADD   | add multiplicand (or 0) into product upper half
  // SHIFT | shift product and multiplier right, count the iteration
  // DONE  | result valid on p, waiting for ack
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_LOAD  = 3'd2,
    S_ADD   = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_ADD;
      end
      S_ADD: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // the final iteration leaves cnt at N so the count never wraps
        if (cnt_q == CW'(N - 1)) state_d = S_DONE;
        else                     state_d = S_ADD;
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // pclr also follows the reset input so the datapath is held clear during reset
  assign pclr = clr | (state_q == S_CLEAR);
  assign ld   = (state_q == S_LOAD);
  assign ldp  = (state_q == S_ADD);
  assign shp  = (state_q == S_SHIFT);
  assign shb  = (state_q == S_SHIFT);
  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl: cycle-table check of one operation, a behavioural
// shift-add datapath driven by the strobes, and a product scoreboard.
module tb_mult_ctrl;

  localparam int N = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic pclr, ld, ldp, shp, shb, busy, done;

  int checks = 0;
  int errors = 0;

  mult_ctrl #(.N(N)) dut (
    .clk  (clk),
    .clr  (clr),
    .start(start),
    .ack  (ack),
    .pclr (pclr),
    .ld   (ld),
    .ldp  (ldp),
    .shp  (shp),
    .shb  (shb),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  // behavioural datapath: a_q multiplicand, b_q multiplier, p9 = {carry, p[7:0]}
  logic [3:0] da = 4'd0, db = 4'd0;
  logic [3:0] a_q = 4'd0, b_q = 4'd0;
  logic [8:0] p9 = 9'd0;

  always @(posedge clk) begin
    if (pclr)     p9 <= 9'd0;
    else if (ldp) p9[8:4] <= {1'b0, p9[7:4]} + {1'b0, (b_q[0] ? a_q : 4'd0)};
    else if (shp) p9 <= p9 >> 1;
    if (ld)       begin a_q <= da; b_q <= db; end
    else if (shb) b_q <= b_q >> 1;
  end

  // scoreboard: expected product pushed at start, popped when done rises
  logic [7:0] sb[$];
  logic [7:0] sb_exp;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    if (done && !done_prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL product_unexpected: done rose with nothing pending, p=%0d", p9[7:0]);
      end else begin
        sb_exp = sb.pop_front();
        if (p9[7:0] !== sb_exp) begin
          errors++;
          $display("FAIL product: got %0d expected %0d", p9[7:0], sb_exp);
        end
      end
    end
    done_prev = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // order: {pclr, ld, ldp, shp, shb, busy, done}
  task automatic check_vec(input string name, input logic [6:0] exp);
    logic [6:0] act;
    act = {pclr, ld, ldp, shp, shb, busy, done};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs %b expected %b", name, act, exp);
    end
  endtask

  // counts cycles until done (bounded); start is dropped after the first cycle unless held
  task automatic wait_done(input string name, input int exp_lat, input bit hold_start);
    int lat;
    lat = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
      if (!hold_start) start = 1'b0;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s: done after %0d cycles expected %0d", name, lat, exp_lat);
    end
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b);
    da = a;
    db = b;
    sb.push_back(8'(a * b));
    start = 1'b1;
    wait_done("op_latency", 2 * N + 3, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_vec("op_after_ack", 7'b0000000);
  endtask

  typedef struct {
    logic       st;
    logic       ak;
    logic [6:0] exp;
  } vec_t;

  vec_t tv[16];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 7'b0000000};
    tv[1]  = '{1'b0, 1'b0, 7'b1000010};
    tv[2]  = '{1'b0, 1'b0, 7'b0100010};
    tv[3]  = '{1'b0, 1'b0, 7'b0010010};
    tv[4]  = '{1'b0, 1'b0, 7'b0001110};
    tv[5]  = '{1'b0, 1'b0, 7'b0010010};
    tv[6]  = '{1'b0, 1'b0, 7'b0001110};
    tv[7]  = '{1'b0, 1'b0, 7'b0010010};
    tv[8]  = '{1'b0, 1'b0, 7'b0001110};
    tv[9]  = '{1'b0, 1'b0, 7'b0010010};
    tv[10] = '{1'b0, 1'b0, 7'b0001110};
    tv[11] = '{1'b0, 1'b0, 7'b0000011};
    tv[12] = '{1'b0, 1'b0, 7'b0000011};
    tv[13] = '{1'b0, 1'b0, 7'b0000011};
    tv[14] = '{1'b0, 1'b1, 7'b0000011};
    tv[15] = '{1'b0, 1'b0, 7'b0000000};

    #1 clr = 1'b1;
    #1 check_vec("reset_hold", 7'b1000000);
    tick();
    tick();
    clr = 1'b0;
    #1 check_vec("reset_release", 7'b0000000);
    tick();

    // single operation, cycle by cycle
    for (int i = 0; i < 16; i++) begin
      start = tv[i].st;
      ack   = tv[i].ak;
      if (i == 0) begin
        da = 4'd13;
        db = 4'd11;
        sb.push_back(8'd143);
      end
      check_vec($sformatf("seq_cycle%0d", i), tv[i].exp);
      tick();
    end
    start = 1'b0;
    ack   = 1'b0;

    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd14);

    // start held through the op, then start+ack together in DONE
    da = 4'd6;
    db = 4'd7;
    sb.push_back(8'd42);
    start = 1'b1;
    wait_done("held_latency", 2 * N + 3, 1'b1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_vec("ack_wins_idle", 7'b0000000);
    da = 4'd3;
    db = 4'd5;
    sb.push_back(8'd15);
    tick();
    check_vec("restart_clear", 7'b1000010);
    start = 1'b0;
    wait_done("restart_latency", 2 * N + 2, 1'b0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_vec("restart_ack", 7'b0000000);

    // reset during SHIFT with cnt=1
    da = 4'd13;
    db = 4'd11;
    sb.push_back(8'd143);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_vec("mid_shift", 7'b0001110);
    clr = 1'b1;
    #1 check_vec("clr_async", 7'b1000000);
    sb.delete();
    tick();
    tick();
    clr = 1'b0;
    #1 check_vec("clr_release", 7'b0000000);
    for (int i = 0; i < 12; i++) tick();
    check_vec("clr_no_done", 7'b0000000);
    run_op(4'd13, 4'd11);

    // done held while ack is withheld
    da = 4'd10;
    db = 4'd12;
    sb.push_back(8'd120);
    start = 1'b1;
    wait_done("delay_latency", 2 * N + 3, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_vec($sformatf("ack_delay%0d", i), 7'b0000011);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check_vec("delay_ack", 7'b0000000);

    // ack in IDLE changes nothing
    ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec($sformatf("spurious_ack%0d", i), 7'b0000000);
    end
    ack = 1'b0;
    run_op(4'd2, 4'd3);

    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drained: %0d products pending expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
